// File: rtl/gray2rgb_pkg.sv
// Shared widths, monitor state type and the gray-to-RGB replication helper
// for the 4-pixel-per-clock gray/RGB video blocks.
package gray2rgb_pkg;

    localparam int unsigned PPC         = 4;
    localparam int unsigned GRAY_W      = 8;
    localparam int unsigned RGB_W       = 24;
    localparam int unsigned TDATA_IN_W  = PPC * GRAY_W;
    localparam int unsigned TDATA_OUT_W = PPC * RGB_W;

    typedef enum logic [0:0] {
        WAIT_SOF,
        ACTIVE
    } mon_state_e;

    function automatic logic [TDATA_OUT_W-1:0] gray_to_rgb(input logic [TDATA_IN_W-1:0] gray);
        logic [TDATA_OUT_W-1:0] rgb;
        rgb = '0;
        for (int i = 0; i < int'(PPC); i++) begin
            rgb[RGB_W*i +: RGB_W] = {3{gray[GRAY_W*i +: GRAY_W]}};
        end
        return rgb;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry AXI4-Stream register slice: a main output register plus a
// skid register, with a registered upstream ready for full-rate backpressure.
module axis_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [Width-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [Width-1:0] main_data_q, main_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             drain;

    always_comb begin
        accept       = s_valid_i & ready_q;
        drain        = main_valid_q & m_ready_i;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (drain || !main_valid_q) begin
            // Skid can only be full while ready is low, so it never races an accept.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = s_data_i;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_data_q  <= '0;
            skid_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_data_o  = main_data_q;
    assign m_valid_o = main_valid_q;

endmodule

// File: rtl/gray2rgb_uhd_4ppc.sv
// 4ppc gray-to-RGB stream converter with a registered skid slice and an inline
// frame-format monitor raising sticky line/frame error flags.
module gray2rgb_uhd_4ppc
    import gray2rgb_pkg::*;
#(
    parameter int unsigned BEATS_PER_LINE  = 960,
    parameter int unsigned LINES_PER_FRAME = 2160
) (
    input  logic                   s_axis_video_aclk,
    input  logic                   s_axis_video_areset,
    input  logic [TDATA_IN_W-1:0]  VIDEO_IN_tdata,
    input  logic                   VIDEO_IN_tuser,
    input  logic                   VIDEO_IN_tlast,
    input  logic                   VIDEO_IN_tvalid,
    output logic                   VIDEO_IN_tready,
    output logic [TDATA_OUT_W-1:0] VIDEO_OUT_tdata,
    output logic                   VIDEO_OUT_tuser,
    output logic                   VIDEO_OUT_tlast,
    output logic                   VIDEO_OUT_tvalid,
    input  logic                   VIDEO_OUT_tready,
    input  logic                   err_clr,
    output logic                   err_eol_early,
    output logic                   err_eol_late,
    output logic                   err_sof_early,
    output logic                   frame_done
);

    localparam logic [9:0]  LastBeat = 10'(BEATS_PER_LINE - 1);
    localparam logic [11:0] LastLine = 12'(LINES_PER_FRAME - 1);

    axis_skid_buf #(
        .Width (TDATA_OUT_W + 2)
    ) u_skid (
        .clk_i     (s_axis_video_aclk),
        .rst_i     (s_axis_video_areset),
        .s_data_i  ({gray_to_rgb(VIDEO_IN_tdata), VIDEO_IN_tuser, VIDEO_IN_tlast}),
        .s_valid_i (VIDEO_IN_tvalid),
        .s_ready_o (VIDEO_IN_tready),
        .m_data_o  ({VIDEO_OUT_tdata, VIDEO_OUT_tuser, VIDEO_OUT_tlast}),
        .m_valid_o (VIDEO_OUT_tvalid),
        .m_ready_i (VIDEO_OUT_tready)
    );

    mon_state_e  state_q;
    logic [9:0]  beat_cnt_q;
    logic [11:0] line_cnt_q;
    logic        err_eol_early_q, err_eol_late_q, err_sof_early_q, frame_done_q;

    logic        in_acc, sof_hit, active, eol;
    logic        sof_err, eol_early_err, eol_late_err, frame_end;
    logic [9:0]  cur_beat;
    logic [11:0] cur_line;

    // SOF handling is resolved first; cur_* are the coordinates EOL logic then sees.
    always_comb begin
        in_acc        = VIDEO_IN_tvalid & VIDEO_IN_tready;
        sof_hit       = in_acc & VIDEO_IN_tuser;
        active        = sof_hit | (state_q == ACTIVE);
        cur_beat      = sof_hit ? 10'd0 : beat_cnt_q;
        cur_line      = sof_hit ? 12'd0 : line_cnt_q;
        sof_err       = sof_hit & (state_q == ACTIVE) & ((beat_cnt_q != 10'd0) | (line_cnt_q != 12'd0));
        eol           = in_acc & active & VIDEO_IN_tlast;
        eol_early_err = eol & (cur_beat < LastBeat);
        eol_late_err  = in_acc & active & !VIDEO_IN_tlast & (cur_beat == LastBeat);
        frame_end     = eol & (cur_line == LastLine);
    end

    always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
        if (s_axis_video_areset) begin
            state_q         <= WAIT_SOF;
            beat_cnt_q      <= '0;
            line_cnt_q      <= '0;
            err_eol_early_q <= 1'b0;
            err_eol_late_q  <= 1'b0;
            err_sof_early_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            err_eol_early_q <= (err_eol_early_q & ~err_clr) | eol_early_err;
            err_eol_late_q  <= (err_eol_late_q & ~err_clr) | eol_late_err;
            err_sof_early_q <= (err_sof_early_q & ~err_clr) | sof_err;
            frame_done_q    <= frame_end;
            if (in_acc && active) begin
                if (VIDEO_IN_tlast) begin
                    beat_cnt_q <= '0;
                    if (frame_end) begin
                        line_cnt_q <= '0;
                        state_q    <= WAIT_SOF;
                    end else begin
                        line_cnt_q <= cur_line + 12'd1;
                        state_q    <= ACTIVE;
                    end
                end else begin
                    state_q    <= ACTIVE;
                    line_cnt_q <= cur_line;
                    beat_cnt_q <= (cur_beat == LastBeat) ? cur_beat : cur_beat + 10'd1;
                end
            end
        end
    end

    assign err_eol_early = err_eol_early_q;
    assign err_eol_late  = err_eol_late_q;
    assign err_sof_early = err_sof_early_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_gray2rgb_uhd_4ppc.sv
// Scoreboard bench for gray2rgb_uhd_4ppc with a small 4-beat x 3-line frame.
module tb_gray2rgb_uhd_4ppc;

    localparam int unsigned BPL = 4;
    localparam int unsigned LPF = 3;

    typedef struct packed {
        logic [95:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_user = 1'b0, in_last = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] out_data;
    logic        out_user, out_last, out_valid;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        eol_early, eol_late, sof_early, fdone;

    logic        rand_rdy = 1'b0;
    logic        rdy_force = 1'b1;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          out_fires = 0;
    int          fd_cnt = 0;
    logic        prev_stall = 1'b0;
    beat_t       prev_beat;
    logic        prev_rdy_low = 1'b0;

    gray2rgb_uhd_4ppc #(
        .BEATS_PER_LINE  (BPL),
        .LINES_PER_FRAME (LPF)
    ) dut (
        .s_axis_video_aclk   (clk),
        .s_axis_video_areset (rst),
        .VIDEO_IN_tdata      (in_data),
        .VIDEO_IN_tuser      (in_user),
        .VIDEO_IN_tlast      (in_last),
        .VIDEO_IN_tvalid     (in_valid),
        .VIDEO_IN_tready     (in_ready),
        .VIDEO_OUT_tdata     (out_data),
        .VIDEO_OUT_tuser     (out_user),
        .VIDEO_OUT_tlast     (out_last),
        .VIDEO_OUT_tvalid    (out_valid),
        .VIDEO_OUT_tready    (out_ready),
        .err_clr             (err_clr),
        .err_eol_early       (eol_early),
        .err_eol_late        (eol_late),
        .err_sof_early       (sof_early),
        .frame_done          (fdone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each RGB channel of pixel i is simply gray value i.
    function automatic logic [95:0] expand(input logic [31:0] g);
        logic [95:0] r;
        for (int i = 0; i < 4; i++) r[24*i +: 24] = 24'(g[8*i +: 8]) * 24'h010101;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Input observer: record expected output for every accepted beat.
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready) sb.push_back('{expand(in_data), in_user, in_last});
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            prev_rdy_low = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_stable", {out_data, out_user, out_last}, prev_beat);
            end
            if (prev_rdy_low) check("in_ready_recovers", in_ready, 1);
            if (out_valid && out_ready) begin
                out_fires++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("out_beat", {out_data, out_user, out_last}, e);
                end
            end
            if (fdone) fd_cnt++;
            prev_stall   = out_valid && !out_ready;
            prev_beat    = '{out_data, out_user, out_last};
            prev_rdy_low = !in_ready && out_ready;
        end
    end

    task automatic send(input logic [31:0] d, input logic u, input logic l);
        int n;
        n = 0;
        in_data  = d;
        in_user  = u;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        wait_cycles(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {eol_early, eol_late, sof_early, fdone}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready, 1);
    endtask

    task automatic send_line(input int line, input int nbeats, input logic sof);
        for (int b = 0; b < nbeats; b++)
            send($urandom, sof && (line == 0) && (b == 0), b == nbeats - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int start, fires0, fd0, gap;

        // Reset state and single-beat latency.
        rdy_force = 1'b1;
        do_reset();
        send(32'h04030201, 1'b1, 1'b0);
        check("lat_valid", out_valid, 1);
        check("lat_user", out_user, 1);
        check("lat_data", out_data, 96'h040404_030303_020202_010101);
        wait_cycles(3);

        // Clean frame at full rate.
        do_reset();
        fd0   = fd_cnt;
        fires0 = out_fires;
        start = cyc;
        for (int ln = 0; ln < int'(LPF); ln++) send_line(ln, BPL, 1'b1);
        check("full_rate_cycles", 96'(cyc - start), 12);
        wait_cycles(3);
        check("full_frame_beats", 96'(out_fires - fires0), 12);
        check("full_frame_done", 96'(fd_cnt - fd0), 1);
        check("full_frame_flags", {eol_early, eol_late, sof_early}, 0);

        // Random valid and ready over three frames.
        fd0      = fd_cnt;
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int ln = 0; ln < int'(LPF); ln++) begin
                for (int b = 0; b < int'(BPL); b++) begin
                    gap = $urandom_range(0, 2);
                    for (int k = 0; k < gap; k++) wait_cycles(1);
                    send($urandom, (ln == 0) && (b == 0), b == int'(BPL) - 1);
                end
            end
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        wait_cycles(10);
        check("rand_drained", 96'(sb.size()), 0);
        check("rand_frames", 96'(fd_cnt - fd0), 3);
        check("rand_flags", {eol_early, eol_late, sof_early}, 0);

        // Early end of line.
        do_reset();
        send($urandom, 1'b1, 1'b0);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b1);
        wait_cycles(2);
        check("eol_early_set", eol_early, 1);
        wait_cycles(4);
        check("eol_early_held", eol_early, 1);
        err_clr = 1'b1;
        wait_cycles(1);
        err_clr = 1'b0;
        check("eol_early_clr", eol_early, 0);

        // Late end of line, then SOF mid-frame restarting the count.
        do_reset();
        fd0 = fd_cnt;
        send($urandom, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b1);
        wait_cycles(2);
        check("eol_late_set", eol_late, 1);
        check("sof_not_yet", sof_early, 0);
        for (int ln = 0; ln < int'(LPF); ln++) send_line(ln, BPL, 1'b1);
        wait_cycles(3);
        check("sof_early_set", sof_early, 1);
        check("restart_frame_done", 96'(fd_cnt - fd0), 1);
        check("restart_no_early", eol_early, 0);

        // Reset with both buffer entries occupied and output stalled.
        rdy_force = 1'b0;
        wait_cycles(2);
        send(32'hAAAAAAAA, 1'b1, 1'b0);
        send(32'h55555555, 1'b0, 1'b0);
        check("buf_full_ready", in_ready, 0);
        check("buf_full_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        do_reset();
        rdy_force = 1'b1;
        fires0    = out_fires;
        wait_cycles(6);
        check("no_stale_beats", 96'(out_fires - fires0), 0);
        check("no_stale_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray2rgb_uhd_4ppc.md
Name: gray2rgb_uhd_4ppc

Overview:
- Converts a 4-pixel-per-clock 8-bit grayscale AXI4-Stream video stream (32-bit tdata) back to 4ppc 24-bit RGB (96-bit tdata) for display/debug output of tracker imagery.
- Each pixel is replicated into all three channels. The datapath is fully registered with a 2-entry skid buffer, so backpressure is correct at full throughput.
- An inline frame-format monitor counts beats and lines and raises sticky error flags.
- Sits between the gray-domain processing chain and the RGB video output subsystem.

Parameters:
- BEATS_PER_LINE, 960, accepted beats per line (3840 px / 4).
- LINES_PER_FRAME, 2160, lines per frame.

Ports:
- s_axis_video_aclk  in  1  clock.
- s_axis_video_areset  in  1  reset; asynchronous, active-high.
- VIDEO_IN_tdata  in  32  4 gray pixels, pixel i at bits [8*i+:8].
- VIDEO_IN_tuser  in  1  start of frame.
- VIDEO_IN_tlast  in  1  end of line.
- VIDEO_IN_tvalid  in  1  input valid.
- VIDEO_IN_tready  out  1  input ready.
- VIDEO_OUT_tdata  out  96  4 RGB pixels, pixel i at bits [24*i+:24]; each 8-bit field equals gray pixel i.
- VIDEO_OUT_tuser  out  1  forwarded SOF.
- VIDEO_OUT_tlast  out  1  forwarded EOL.
- VIDEO_OUT_tvalid  out  1  output valid.
- VIDEO_OUT_tready  in  1  output ready.
- err_clr  in  1  single-cycle clear of sticky error flags.
- err_eol_early  out  1  sticky: tlast before BEATS_PER_LINE beats.
- err_eol_late  out  1  sticky: more than BEATS_PER_LINE beats without tlast.
- err_sof_early  out  1  sticky: tuser in the middle of a frame.
- frame_done  out  1  one-cycle pulse on acceptance of the last beat of the last line.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; VIDEO_IN_tready goes to 1 on the first clock after reset deassertion. Buffers empty, counters 0, FSM in WAIT_SOF. Reset mid-frame discards all buffered beats.
- Handshake:
  - Input beat accepted when VIDEO_IN_tvalid & VIDEO_IN_tready.
  - Output beat transferred when VIDEO_OUT_tvalid & VIDEO_OUT_tready.
  - VIDEO_OUT_* is stable while tvalid=1 and tready=0.
- Skid buffer:
  - Holds a main output register plus a skid register.
  - VIDEO_IN_tready is registered and equals !skid_valid.
  - An accepted beat goes to the main register if it is empty or draining this cycle; otherwise it goes to skid.
  - When main drains, skid moves into main.
- Latency and throughput:
  - Latency: 1 cycle from input acceptance to VIDEO_OUT_tvalid when the output is idle.
  - Throughput: 1 beat per cycle with VIDEO_OUT_tready held high.
  - Order is preserved; no beat is ever dropped or duplicated.
- Datapath: for i = 0..3, out[24*i+:24] = {g_i, g_i, g_i}, g_i = in[8*i+:8]. No arithmetic and no width growth.
- Monitor:
  - Operates only on accepted input beats; it never stalls or alters the stream.
  - Counters: beat_cnt (10 b) and line_cnt (12 b).
  - FSM WAIT_SOF: beats without tuser pass through uncounted. A beat with tuser moves to ACTIVE and is counted as beat 0 of line 0.
  - FSM ACTIVE, beat with tuser while beat_cnt != 0 or line_cnt != 0: set err_sof_early, restart counting with this beat as beat 0 of line 0.
  - ACTIVE, beat with tlast: if beat_cnt+1 < BEATS_PER_LINE, set err_eol_early. Then beat_cnt := 0 and line_cnt increments.
  - ACTIVE, beat without tlast where beat_cnt = BEATS_PER_LINE-1: set err_eol_late and saturate beat_cnt (no further wrap until tlast).
  - ACTIVE, tlast while line_cnt = LINES_PER_FRAME-1: pulse frame_done next cycle, line_cnt := 0, FSM to WAIT_SOF.
  - A beat carrying tuser and tlast together: SOF handling is applied first, then EOL handling.
- Sticky flags: set on the cycle after the offending beat and held until err_clr. If err_clr and a new error occur in the same cycle, set wins.

Decomposition:
- Package gray2rgb_pkg:
  - PPC=4, GRAY_W=8, RGB_W=24, TDATA_IN_W=32, TDATA_OUT_W=96.
  - Monitor state enum {WAIT_SOF, ACTIVE}.
- One sub-module, axis_skid_buf: a generic width-parameterised 2-entry register slice carrying {tdata, tuser, tlast}, reusable by other video blocks.
- Top level: replication logic plus monitor FSM and counters.

Test Plan (bench parameters BEATS_PER_LINE=4, LINES_PER_FRAME=3):
- Reset then stream one beat 0x04030201 with tuser=1 -> after 1 cycle VIDEO_OUT_tdata=0x040404_030303_020202_010101, tuser=1, tvalid=1.
- Full frame of 12 beats with tlast on every 4th beat, VIDEO_OUT_tready=1 -> 12 output beats in consecutive cycles, frame_done pulses once, all error flags 0.
- Randomised VIDEO_OUT_tready (50%) with random VIDEO_IN_tvalid over 3 frames -> output sequence identical to input, VIDEO_IN_tready never low for more than 1 cycle while VIDEO_OUT_tready=1.
- tlast on beat 2 of a line -> err_eol_early=1 and stays 1; err_clr pulse -> 0.
- 5 beats without tlast -> err_eol_late=1; tuser on line 1 -> err_sof_early=1, counting restarts, and a following clean frame produces frame_done.
- Assert reset with 2 beats buffered and output stalled -> VIDEO_OUT_tvalid=0 immediately; no stale beat appears after release.
